// File: rtl/vinho_pkg.sv
// Shared definitions for the bottling-line sealing station.
// The cork magazine defaults are shared by the magazine manager and the sealing FSM bench.
package vinho_pkg;

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    PEDINDO      = 2'd1,
    ESPERA_BAIXA = 2'd2,
    FALHA        = 2'd3
  } estado_rolhas_t;

  localparam int WIDTH_PADRAO          = 5;
  localparam int CAPACIDADE_PADRAO     = 20;
  localparam int NIVEL_MINIMO_PADRAO   = 5;
  localparam int LOTE_REPOSICAO_PADRAO = 15;
  localparam int TIMEOUT_CICLOS_PADRAO = 255;

endpackage

// File: rtl/gestor_rolhas_contador_saturado.sv
// Next cork count: adds the increment, removes one cork on request and clamps to [0, MAX].
// A decrement that would take the count below zero is flagged as an underflow.
module contador_saturado #(
  parameter int WIDTH = 5,
  parameter int MAX   = 20
) (
  input  logic [WIDTH-1:0] atual,
  input  logic [WIDTH:0]   incremento,
  input  logic             decremento,
  output logic [WIDTH-1:0] proximo,
  output logic             subfluxo
);

  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX);

  logic [WIDTH:0] soma_s;
  logic [WIDTH:0] liquido_s;

  assign soma_s    = {1'b0, atual} + incremento;
  assign liquido_s = soma_s - {{WIDTH{1'b0}}, decremento};

  // Clamp the net result; a decrement only underflows when nothing else arrived to cover it
  always_comb begin
    subfluxo = 1'b0;
    proximo  = {WIDTH{1'b0}};
    if (decremento && (soma_s == {(WIDTH+1){1'b0}})) begin
      subfluxo = 1'b1;
      proximo  = {WIDTH{1'b0}};
    end else if (liquido_s > MAX_W) begin
      subfluxo = 1'b0;
      proximo  = MAX_N;
    end else begin
      subfluxo = 1'b0;
      proximo  = liquido_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/gestor_rolhas.sv
// Cork magazine manager: tracks corks in stock and refills the magazine from the feeder
// through a four-phase req/ack handshake with timeout, raising sticky fault flags.
module gestor_rolhas
  import vinho_pkg::*;
#(
  parameter int WIDTH          = WIDTH_PADRAO,
  parameter int CAPACIDADE     = CAPACIDADE_PADRAO,
  parameter int NIVEL_MINIMO   = NIVEL_MINIMO_PADRAO,
  parameter int LOTE_REPOSICAO = LOTE_REPOSICAO_PADRAO,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             DECREMENTA_ROLHA,
  input  logic             ADICIONA_ROLHA,
  input  logic             REPOSICAO_ACK,
  input  logic             LIMPA_FALHA,
  output logic             ROLHAS_DISPONIVEIS,
  output logic             NIVEL_BAIXO,
  output logic [WIDTH-1:0] CONTAGEM,
  output logic             REPOSICAO_REQ,
  output logic             FALHA_REPOSICAO,
  output logic             ERRO_SUBFLUXO
);

  localparam logic [WIDTH-1:0] CAPACIDADE_N = WIDTH'(CAPACIDADE);
  localparam logic [WIDTH-1:0] NIVEL_N      = WIDTH'(NIVEL_MINIMO);
  localparam logic [WIDTH:0]   LOTE_N       = (WIDTH+1)'(LOTE_REPOSICAO);
  localparam logic [7:0]       TIMEOUT_N    = 8'(TIMEOUT_CICLOS);

  estado_rolhas_t   estado_r, estado_s;
  logic [7:0]       timer_r, timer_s;
  logic [WIDTH-1:0] contagem_r, proximo_s;
  logic [WIDTH:0]   incremento_s;
  logic             aceita_lote_s, timeout_s, subfluxo_s, nivel_baixo_s;
  logic             req_r, falha_r, erro_r;

  assign nivel_baixo_s = (contagem_r <= NIVEL_N);
  assign incremento_s  = (aceita_lote_s ? LOTE_N : {(WIDTH+1){1'b0}})
                       + {{WIDTH{1'b0}}, ADICIONA_ROLHA};

  contador_saturado #(
    .WIDTH (WIDTH),
    .MAX   (CAPACIDADE)
  ) u_contador (
    .atual      (contagem_r),
    .incremento (incremento_s),
    .decremento (DECREMENTA_ROLHA),
    .proximo    (proximo_s),
    .subfluxo   (subfluxo_s)
  );

  // Feeder handshake next state; a batch is accepted only on the PEDINDO cycle that sees ACK
  always_comb begin
    estado_s      = estado_r;
    timer_s       = timer_r;
    aceita_lote_s = 1'b0;
    timeout_s     = 1'b0;
    case (estado_r)
      OCIOSO: begin
        if (nivel_baixo_s) begin
          estado_s = PEDINDO;
          timer_s  = 8'd0;
        end else begin
          estado_s = OCIOSO;
        end
      end
      PEDINDO: begin
        if (REPOSICAO_ACK) begin
          aceita_lote_s = 1'b1;
          estado_s      = ESPERA_BAIXA;
        end else if (timer_r == TIMEOUT_N) begin
          timeout_s = 1'b1;
          estado_s  = FALHA;
        end else begin
          timer_s = timer_r + 8'd1;
        end
      end
      ESPERA_BAIXA: begin
        if (!REPOSICAO_ACK) begin
          estado_s = OCIOSO;
        end else begin
          estado_s = ESPERA_BAIXA;
        end
      end
      FALHA: begin
        if (LIMPA_FALHA) begin
          estado_s = OCIOSO;
        end else begin
          estado_s = FALHA;
        end
      end
      default: begin
        estado_s = OCIOSO;
        timer_s  = 8'd0;
      end
    endcase
  end

  // State, stock and sticky fault registers; a new fault outranks a clear in the same cycle
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      estado_r   <= OCIOSO;
      timer_r    <= 8'd0;
      contagem_r <= CAPACIDADE_N;
      req_r      <= 1'b0;
      falha_r    <= 1'b0;
      erro_r     <= 1'b0;
    end else begin
      estado_r   <= estado_s;
      timer_r    <= timer_s;
      contagem_r <= proximo_s;
      req_r      <= (estado_s == PEDINDO);
      if (timeout_s) begin
        falha_r <= 1'b1;
      end else if (LIMPA_FALHA) begin
        falha_r <= 1'b0;
      end else begin
        falha_r <= falha_r;
      end
      if (subfluxo_s) begin
        erro_r <= 1'b1;
      end else if (LIMPA_FALHA) begin
        erro_r <= 1'b0;
      end else begin
        erro_r <= erro_r;
      end
    end
  end

  assign CONTAGEM           = contagem_r;
  assign ROLHAS_DISPONIVEIS = (contagem_r != {WIDTH{1'b0}});
  assign NIVEL_BAIXO        = nivel_baixo_s;
  assign REPOSICAO_REQ      = req_r;
  assign FALHA_REPOSICAO    = falha_r;
  assign ERRO_SUBFLUXO      = erro_r;

endmodule
